// File: rtl/cpu_if.sv
// Instruction fetch bus between the core and its instruction memory.
// The core drives pc; the memory returns the addressed word combinationally.
interface cpu_if;
  logic [31:0] pc;
  logic [31:0] instruction;

  modport master (output pc, input instruction);
  modport slave  (input pc, output instruction);
endinterface

// File: rtl/cpu.sv
// Single-cycle 8-bit core: PC, 8x8 register file, ALU and decode.
// One instruction retires per rising edge; reset is asynchronous, active-low.
module reg_file (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] read_addr_a,
  input  logic [2:0] read_addr_b,
  output logic [7:0] read_data_a,
  output logic [7:0] read_data_b,
  input  logic       write_en,
  input  logic [2:0] write_addr,
  input  logic [7:0] write_data
);
  logic [7:0] registerArray [0:7];

  assign read_data_a = registerArray[read_addr_a];
  assign read_data_b = registerArray[read_addr_b];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) registerArray[i] <= '0;
    end else if (write_en) begin
      registerArray[write_addr] <= write_data;
    end
  end
endmodule

module cpu (
  input logic clk,
  input logic reset,
  cpu_if.master bus
);
  typedef enum logic [7:0] {
    OP_LOADI = 8'h00,
    OP_MOV   = 8'h01,
    OP_ADD   = 8'h02,
    OP_SUB   = 8'h03,
    OP_AND   = 8'h04,
    OP_OR    = 8'h05,
    OP_J     = 8'h06,
    OP_BEQ   = 8'h07
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_PASS_B,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } alu_op_t;

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] offset_ext;
  logic [31:0] pc_next;
  logic [7:0]  opcode;
  logic [7:0]  dest_field;
  logic [7:0]  src1_field;
  logic [7:0]  src2_field;
  logic [7:0]  rs1_data;
  logic [7:0]  rs2_data;
  logic [7:0]  operand_b;
  logic [7:0]  alu_result;
  logic        alu_zero;
  alu_op_t     alu_op;
  logic        write_en;
  logic        use_imm;
  logic        is_jump;
  logic        is_beq;
  logic        branch_taken;
  logic        unused_src1_hi;

  assign opcode     = bus.instruction[31:24];
  assign dest_field = bus.instruction[23:16];
  assign src1_field = bus.instruction[15:8];
  assign src2_field = bus.instruction[7:0];

  // Only the low 3 bits of a source-register field select a register.
  assign unused_src1_hi = ^src1_field[7:3];

  reg_file registerFile (
    .clk         (clk),
    .reset       (reset),
    .read_addr_a (src1_field[2:0]),
    .read_addr_b (src2_field[2:0]),
    .read_data_a (rs1_data),
    .read_data_b (rs2_data),
    .write_en    (write_en),
    .write_addr  (dest_field[2:0]),
    .write_data  (alu_result)
  );

  always_comb begin
    alu_op   = ALU_PASS_B;
    write_en = 1'b0;
    use_imm  = 1'b0;
    is_jump  = 1'b0;
    is_beq   = 1'b0;
    case (opcode)
      OP_LOADI: begin write_en = 1'b1; use_imm = 1'b1; end
      OP_MOV:   write_en = 1'b1;
      OP_ADD:   begin write_en = 1'b1; alu_op = ALU_ADD; end
      OP_SUB:   begin write_en = 1'b1; alu_op = ALU_SUB; end
      OP_AND:   begin write_en = 1'b1; alu_op = ALU_AND; end
      OP_OR:    begin write_en = 1'b1; alu_op = ALU_OR; end
      OP_J:     is_jump = 1'b1;
      OP_BEQ:   begin is_beq = 1'b1; alu_op = ALU_SUB; end
      default:  ;
    endcase
  end

  assign operand_b = use_imm ? src2_field : rs2_data;

  always_comb begin
    alu_result = operand_b;
    case (alu_op)
      ALU_ADD: alu_result = rs1_data + operand_b;
      ALU_SUB: alu_result = rs1_data + (~operand_b + 8'd1);
      ALU_AND: alu_result = rs1_data & operand_b;
      ALU_OR:  alu_result = rs1_data | operand_b;
      default: alu_result = operand_b;
    endcase
  end

  assign alu_zero = (alu_result == 8'd0);

  // Branch offset counts words relative to the following instruction.
  assign pc_plus4     = pc_q + 32'd4;
  assign offset_ext   = {{22{dest_field[7]}}, dest_field, 2'b00};
  assign branch_taken = is_jump | (is_beq & alu_zero);
  assign pc_next      = branch_taken ? (pc_plus4 + offset_ext) : pc_plus4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_next;
  end

  assign bus.pc = pc_q;
endmodule

// File: tb/tb_cpu.sv
// Directed bench for the single-cycle core: programs are loaded into a
// local instruction memory and expected pc/register values go through a queue.
module tb_cpu;
  localparam logic [31:0] NOP = 32'hFF00_0000;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] imem [0:63];
  exp_t        sb [$];
  int          n_assert;
  int          n_fail;

  cpu_if bus ();

  cpu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  assign bus.instruction = imem[bus.pc[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench timeout");
  end

  function automatic logic [31:0] observe(input int sel);
    logic [2:0] idx;
    idx = sel[2:0];
    if (sel < 0) return bus.pc;
    return {24'h0, dut.registerFile.registerArray[idx]};
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_all_zero(input string tag);
    for (int i = 0; i < 8; i++) expect_val($sformatf("%s_r%0d", tag, i), i, 32'h0);
    expect_val($sformatf("%s_pc", tag), -1, 32'h0);
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_assert++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 64; i++) imem[i] = NOP;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart();
    reset = 1'b0;
    run(1);
    fill_nop();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b0;
    fill_nop();

    // reset held for two edges, then sequential fetch
    run(2);
    expect_all_zero("reset_hold");
    check_sb();
    reset = 1'b1;
    run(1); expect_val("seq_pc4", -1, 32'd4);  check_sb();
    run(1); expect_val("seq_pc8", -1, 32'd8);  check_sb();
    run(1); expect_val("seq_pc12", -1, 32'd12); check_sb();

    // load and add
    restart();
    imem[0] = 32'h0004_0005;
    imem[1] = 32'h0002_0009;
    imem[2] = 32'h0206_0402;
    expect_val("ld_r4", 4, 32'd5);
    expect_val("ld_r2", 2, 32'd9);
    expect_val("add_r6", 6, 32'd14);
    expect_val("add_pc", -1, 32'd12);
    reset = 1'b1;
    run(3);
    check_sb();

    // sub wraps, logic ops, mov, and read-before-write on r1 = r1 + r1
    restart();
    imem[0] = 32'h0001_0003;
    imem[1] = 32'h0002_0005;
    imem[2] = 32'h0303_0102;
    imem[3] = 32'h0404_0102;
    imem[4] = 32'h0505_0102;
    imem[5] = 32'h0106_0002;
    imem[6] = 32'h0201_0101;
    expect_val("sub_r3", 3, 32'hFE);
    expect_val("and_r4", 4, 32'h01);
    expect_val("or_r5", 5, 32'h07);
    expect_val("mov_r6", 6, 32'h05);
    expect_val("self_add_r1", 1, 32'h06);
    expect_val("keep_r2", 2, 32'h05);
    expect_val("logic_pc", -1, 32'd28);
    reset = 1'b1;
    run(7);
    check_sb();

    // beq taken: offset +2 at pc 16 goes to 28, no register write
    restart();
    imem[0] = 32'h0001_0007;
    imem[1] = 32'h0002_0007;
    imem[4] = 32'h0702_0102;
    expect_val("beq_t_pc", -1, 32'd28);
    expect_val("beq_t_r1", 1, 32'd7);
    expect_val("beq_t_r2", 2, 32'd7);
    reset = 1'b1;
    run(5);
    check_sb();

    // beq not taken, then backward jump loop between 16 and 20
    restart();
    imem[0] = 32'h0001_0007;
    imem[1] = 32'h0002_0008;
    imem[4] = 32'h0702_0102;
    imem[5] = 32'h06FE_0000;
    expect_val("beq_nt_pc", -1, 32'd20);
    expect_val("beq_nt_r1", 1, 32'd7);
    expect_val("beq_nt_r2", 2, 32'd8);
    expect_val("beq_nt_r0", 0, 32'd0);
    expect_val("beq_nt_r3", 3, 32'd0);
    reset = 1'b1;
    run(5);
    check_sb();
    run(1); expect_val("jback_pc16", -1, 32'd16); check_sb();
    run(1); expect_val("loop_pc20", -1, 32'd20);  check_sb();
    run(1); expect_val("jback2_pc16", -1, 32'd16); check_sb();

    // backward jump from 0 wraps the 32-bit pc, then wraps back to 0
    restart();
    imem[0] = 32'h06FE_0000;
    reset = 1'b1;
    run(1); expect_val("wrap_pc_neg", -1, 32'hFFFF_FFFC); check_sb();
    run(1); expect_val("wrap_pc_zero", -1, 32'h0); check_sb();

    // reset pulled between edges while an add is in flight
    restart();
    imem[0] = 32'h0001_0003;
    imem[1] = 32'h0002_0004;
    imem[2] = 32'h0203_0102;
    reset = 1'b1;
    run(2);
    expect_val("pre_rst_pc", -1, 32'd8);
    expect_val("pre_rst_r1", 1, 32'd3);
    check_sb();
    reset = 1'b0;
    #1;
    expect_all_zero("async_rst");
    check_sb();
    run(1);
    expect_val("rst_nowrite_r3", 3, 32'd0);
    expect_val("rst_held_pc", -1, 32'd0);
    check_sb();
    reset = 1'b1;
    run(3);
    expect_val("resume_r3", 3, 32'd7);
    expect_val("resume_pc", -1, 32'd12);
    check_sb();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu.md
# cpu

Single-cycle 8-bit processor core executing 32-bit instructions fetched from an external instruction memory. It holds the program counter, an 8 x 8-bit register file, an 8-bit ALU and the control decode. Each instruction completes in one clock cycle. The surrounding system (memory model, clock generator) supplies `instruction` combinationally from `pc`.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset. While low, `pc` and all registers are held at 0.
- `instruction`  in  32  instruction word addressed by `pc`, valid before the next rising edge.
- `pc`  out  32  byte address of the current instruction; word-aligned, steps of 4.
- Register file instance is named `registerFile`; its storage array is `registerArray[0:7]` (8 bits each). Benches probe it hierarchically.

## Operation
- Instruction fields:
  - `[31:24]` opcode.
  - `[23:16]` destination register, or branch offset for `j`/`beq`.
  - `[15:8]` source 1 register.
  - `[7:0]` source 2 register or immediate.
- Register indices use the low 3 bits of their field.
- Opcodes:
  - `0x00` loadi: `rd = imm`.
  - `0x01` mov: `rd = rs2`.
  - `0x02` add: `rd = rs1 + rs2`.
  - `0x03` sub: `rd = rs1 - rs2`, computed as `rs1 + (~rs2 + 1)`.
  - `0x04` and: `rd = rs1 & rs2`.
  - `0x05` or: `rd = rs1 | rs2`.
  - `0x06` j: unconditional jump.
  - `0x07` beq: branch if `rs1 == rs2`, equality via ALU subtract zero flag; no register write.
- Any other opcode is a NOP: no register write, `pc += 4`.
- Arithmetic is 8-bit modulo 256. No carry or overflow state is kept.
- Next PC:
  - Default: `pc + 4`.
  - Taken `j`/`beq`: `pc + 4 + (sign_extend(offset[7:0]) << 2)`, where the offset counts words.
  - PC arithmetic is 32-bit and wraps modulo 2^32.
- Register file: two combinational read ports, one synchronous write port. Write enable is asserted only for opcodes `0x00`–`0x05`.
- Reading and writing the same register in one instruction: the read returns the old value; the new value is visible from the next cycle.

## Timing
- Reset low (asynchronous): `pc = 0` and `registerArray[0..7] = 0` immediately, held until reset goes high.
- Reset deassertion (high): the first rising edge executes the instruction at address 0.
- Each rising edge with reset high:
  - commits the register write of the current instruction;
  - loads `pc` with the next PC.
- Latency is one cycle per instruction: a result is readable by the instruction in the following cycle.
- No stalls and no handshake.
- `instruction` may change at any time after a `pc` change. It is only sampled through combinational paths at the rising edge.
- Reset asserted mid-program: the in-flight instruction is abandoned with no write; execution restarts at 0 once reset is released.

## Test plan
- Reset: hold reset low for 2 edges → `pc = 0`, all 8 registers 0; release → `pc` reads 4, 8, 12 on successive edges.
- Load and add:
  - Program: `0x00040005`, `0x00020009`, `0x02060402`.
  - After 3 edges: r4 = 5, r2 = 9, r6 = 14, `pc = 12`.
- Sub and logic:
  - Setup: r1 = 3, r2 = 5.
  - Execute sub r3 = r1 - r2, and r4 = r1 & r2, or r5 = r1 | r2, mov r6 = r2.
  - Expect r3 = 0xFE, r4 = 0x01, r5 = 0x07, r6 = 0x05.
- Branch:
  - Setup: r1 = r2 = 7.
  - beq with offset +2 at `pc = 16` → `pc = 28`.
  - With r2 = 8 → `pc = 20`, no register changes.
- Jump backward: `j` with offset `0xFE` at `pc = 20` → `pc = 16`.
- Reset mid-run:
  - Pull reset low between edges during an add.
  - Expect `pc = 0` and registers 0 immediately, with no write committed.
  - Execution resumes from 0 after release.
